// File: rtl/host_uart_tx_arb.sv
// Round-robin arbiter that feeds bytes from four packet requesters into a
// UART transmitter through a one-byte FIFO-style read interface. Ownership
// is held for a whole packet and passes on after the byte marked last.
module host_uart_tx_arb (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_pop,
    input  logic [3:0]  req_mask,
    input  logic        fifo_rd_en,
    output logic [7:0]  fifo_din,
    output logic        fifo_empty,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        pkt_done,
    output logic [15:0] byte_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]  owner_q, owner_d;
    logic [3:0]  grant_q, grant_d;
    logic [7:0]  din_q, din_d;
    logic [15:0] cnt_q, cnt_d;
    logic        done_q, done_d;

    logic [3:0]  eligible;
    logic        pick_found;
    logic [1:0]  pick_idx;
    logic [1:0]  cand;

    assign eligible = req_valid & req_mask;

    // Round-robin search: first eligible requester starting at rr_ptr.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state logic plus the combinational pop/empty handshake.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        din_d      = din_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        req_pop    = 4'b0000;
        fifo_empty = 1'b1;

        case (state_q)
            ST_IDLE: begin
                grant_d = 4'b0000;
                if (pick_found) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    grant_d = 4'b0001 << pick_idx;
                end
            end
            ST_GRANT: begin
                // The owner keeps the grant even when it runs dry mid-packet.
                fifo_empty = ~req_valid[owner_q];
                if (fifo_rd_en && req_valid[owner_q]) begin
                    req_pop[owner_q] = 1'b1;
                    din_d            = req_data[{owner_q, 3'b000} +: 8];
                    cnt_d            = cnt_q + 16'd1;
                    if (req_last[owner_q]) begin
                        state_d  = ST_IDLE;
                        grant_d  = 4'b0000;
                        rr_ptr_d = owner_q + 2'd1;
                        done_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
            end
        endcase

        // The transmitter and requesters see a quiet interface during reset.
        if (!reset_n) begin
            req_pop    = 4'b0000;
            fifo_empty = 1'b1;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 2'd0;
            owner_q  <= 2'd0;
            grant_q  <= 4'b0000;
            din_q    <= 8'h00;
            cnt_q    <= 16'h0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            din_q    <= din_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q == ST_GRANT);
    assign fifo_din = din_q;
    assign byte_cnt = cnt_q;
    assign pkt_done = done_q;

endmodule

// File: doc/host_uart_tx_arb.md
HOST_UART_TX_ARB -- requirements
Module: host_uart_tx_arb

Interface
REQ-001 The block SHALL expose `clk`, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL expose `reset_n`, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of `clk`.
REQ-003 The block SHALL expose `req_valid`, input, 4 bits: requester i has a byte available.
REQ-004 The block SHALL expose `req_data`, input, 32 bits: requester i's byte on bits [8i+7:8i].
REQ-005 The block SHALL expose `req_last`, input, 4 bits: requester i's current byte is the last byte of its packet.
REQ-006 The block SHALL expose `req_pop`, output, 4 bits: one-cycle pop to requester i; combinational.
REQ-007 The block SHALL expose `req_mask`, input, 4 bits: 1 means requester i may win arbitration.
REQ-008 The block SHALL expose `fifo_rd_en`, input, 1 bit: read strobe from the UART transmitter.
REQ-009 The block SHALL expose `fifo_din`, output, 8 bits: registered byte to the UART transmitter.
REQ-010 The block SHALL expose `fifo_empty`, output, 1 bit: no byte available to the transmitter; combinational.
REQ-011 The block SHALL expose `grant`, output, 4 bits: one-hot current owner; all zeros when none.
REQ-012 The block SHALL expose `busy`, output, 1 bit: 1 while in ST_GRANT.
REQ-013 The block SHALL expose `pkt_done`, output, 1 bit: one-cycle pulse after a packet's last byte is read.
REQ-014 The block SHALL expose `byte_cnt`, output, 16 bits: total bytes delivered since reset.

Function
REQ-015 The block SHALL implement two states: ST_IDLE (00) and ST_GRANT (01); the other codes SHALL return to ST_IDLE.
REQ-016 In ST_IDLE, an eligible requester is one with `req_valid & req_mask` = 1.
REQ-017 In ST_IDLE with at least one eligible requester, the block SHALL pick the first eligible index searching rr_ptr, rr_ptr+1, ... modulo 4.
REQ-018 After the pick in REQ-017, the block SHALL load `grant` and enter ST_GRANT on the next edge, giving one cycle of arbitration latency.
REQ-019 In ST_IDLE, `fifo_empty` SHALL be 1, `req_pop` SHALL be 0 and `grant` SHALL be 0.
REQ-020 In ST_GRANT with owner g, `fifo_empty` SHALL equal ~`req_valid`[g].
REQ-021 A read is defined as `fifo_rd_en` & ~`fifo_empty`.
REQ-022 On a read, `req_pop`[g] SHALL be 1 in the same cycle, and `fifo_din` SHALL load `req_data`[8g+7:8g] at the next edge.
REQ-023 `fifo_din` SHALL hold its value until the next read, because the transmitter samples it bit by bit throughout the frame.
REQ-024 `fifo_rd_en` while `fifo_empty`=1 SHALL be ignored: no pop, and `fifo_din`, `byte_cnt` and state unchanged.
REQ-025 A read with `req_last`[g]=1 SHALL, at the next edge, enter ST_IDLE, clear `grant`, set rr_ptr to (g+1) mod 4 and assert `pkt_done` for one cycle.
REQ-026 Ownership SHALL be packet-atomic.
REQ-027 Deasserting `req_mask`[g] or `req_valid`[g] mid-packet SHALL NOT release the grant; the block SHALL wait, with `fifo_empty`=1, for further bytes.
REQ-028 Each read SHALL increment `byte_cnt` by 1, wrapping from 0xFFFF to 0x0000.
REQ-029 At most one bit of `req_pop` and of `grant` SHALL be 1 in any cycle.
REQ-030 `req_pop` SHALL never assert for a requester whose `req_valid` is 0.
REQ-031 The cycle after `pkt_done`, other requesters SHALL be arbitrated in ST_IDLE, so there is a minimum one-cycle gap between packets.

Reset
REQ-032 While `reset_n`=0 at a rising edge, the block SHALL set: state ST_IDLE, rr_ptr=0, `grant`=0, `fifo_din`=0x00, `byte_cnt`=0, `pkt_done`=0, `busy`=0.
REQ-033 Combinationally during reset, the block SHALL drive `req_pop`=0 and `fifo_empty`=1.
REQ-034 Reset asserted mid-packet SHALL abandon that packet with no further pops; the next arbitration SHALL start from requester 0.

Verification
REQ-035 Single packet: req 2 valid with bytes 0x41, 0x42 (last), mask=0xF, with rd_en pulsed per frame -> grant=0100, fifo_din 0x41 then 0x42, pkt_done once, byte_cnt=2, then rr_ptr=3.
REQ-036 Round robin: reqs 0, 1 and 3 each hold a one-byte packet -> service order 0, 1, 3; repeating, the next order is 0, 1, 3 (rr_ptr wraps to 0 after 3).
REQ-037 Atomicity: req 1 is sending a 3-byte packet while req 0 is valid; drop req_valid[1] for 5 cycles mid-packet -> fifo_empty=1, grant stays 0010, req 0 is not popped until req 1's last byte.
REQ-038 Spurious read: rd_en=1 in ST_IDLE and while the owner has req_valid=0 -> req_pop=0, fifo_din unchanged, byte_cnt unchanged.
REQ-039 Mask and wrap: mask=0x1 with reqs 0 and 1 valid -> only req 0 granted; preload traffic to 65536 bytes -> byte_cnt reads 0x0000.
REQ-040 Reset mid-packet: assert reset_n=0 for one cycle after byte 1 of 3 -> grant=0, fifo_din=0x00, byte_cnt=0, and the next grant goes to the lowest eligible index from 0.
